// File: rtl/imem_loader.sv
// imem_loader: loads the instruction memory from a byte stream.
// Every four accepted bytes form one little-endian 32-bit word. Each word is
// written at the next word address, starting from 0. While the load runs,
// cpu_hold keeps the processor in reset.

module imem_loader_checker (
  input logic clk,
  input logic rst,
  input logic mem_we,
  input logic busy,
  input logic cpu_hold,
  input logic done,
  input logic byte_ready
);

  // A write strobe may only appear inside an active session.
  a_we_in_session: assert property (@(posedge clk) disable iff (rst)
    mem_we |-> (busy && cpu_hold));

  // The write strobe is a single-cycle pulse.
  a_we_pulse: assert property (@(posedge clk) disable iff (rst)
    mem_we |=> !mem_we);

  // The completion flag is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

  // No byte is taken in the cycle that writes a word.
  a_no_accept_in_write: assert property (@(posedge clk) disable iff (rst)
    byte_ready |-> !mem_we);

  // The processor stays held whenever the loader takes bytes.
  a_hold_while_recv: assert property (@(posedge clk) disable iff (rst)
    byte_ready |-> cpu_hold);

endmodule

module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Largest legal length, expressed in the width of load_len.
  localparam logic [ADDR_W:0] MAX_LEN = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W:0]   len_r;       // latched number of words
  logic [ADDR_W-1:0] word_addr_r; // address of the word being assembled
  logic [1:0]        byte_idx_r;  // position of the next byte in the word
  logic [23:0]       asm_r;       // lower three bytes of the current word
  logic              len_ok_s;
  logic              last_word_s;

  // Length check. load_len is unsigned, so anything above MAX_LEN is rejected.
  assign len_ok_s = (load_len != {(ADDR_W+1){1'b0}}) && (load_len <= MAX_LEN);

  // Goes high in WRITE when the word being written is the last of the session.
  assign last_word_s = ({1'b0, word_addr_r} == (len_r - {{ADDR_W{1'b0}}, 1'b1}));

  // Bytes are taken only in RECV, so the handshake is decoded from the state.
  assign byte_ready = (state_r == ST_RECV);

  // Session controller: handshake, word assembly, write strobe and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      len_r       <= {(ADDR_W+1){1'b0}};
      word_addr_r <= {ADDR_W{1'b0}};
      byte_idx_r  <= 2'd0;
      asm_r       <= 24'd0;
      mem_we      <= 1'b0;
      mem_waddr   <= {ADDR_W{1'b0}};
      mem_wdata   <= 32'd0;
      cpu_hold    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_we <= 1'b0;
          done   <= 1'b0;
          if (load_start) begin
            if (len_ok_s) begin
              len_r       <= load_len;
              word_addr_r <= {ADDR_W{1'b0}};
              byte_idx_r  <= 2'd0;
              asm_r       <= 24'd0;
              err         <= 1'b0;
              cpu_hold    <= 1'b1;
              busy        <= 1'b1;
              state_r     <= ST_RECV;
            end else begin
              // Rejected length: flag it and leave the processor running.
              err <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_RECV: begin
          mem_we <= 1'b0;
          if (byte_valid) begin
            if (byte_idx_r == 2'd3) begin
              // The fourth byte completes the word and it is written next cycle.
              mem_wdata  <= {byte_data, asm_r};
              mem_waddr  <= word_addr_r;
              mem_we     <= 1'b1;
              byte_idx_r <= 2'd0;
              asm_r      <= 24'd0;
              state_r    <= ST_WRITE;
            end else begin
              asm_r[{byte_idx_r, 3'b000} +: 8] <= byte_data;
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end else begin
            state_r <= ST_RECV;
          end
        end

        ST_WRITE: begin
          mem_we <= 1'b0;
          if (last_word_s) begin
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            word_addr_r <= word_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_r     <= ST_RECV;
          end
        end

        ST_DONE: begin
          // Release the processor in the same cycle the loader returns to IDLE.
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end

        default: begin
          mem_we   <= 1'b0;
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  imem_loader_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .mem_we     (mem_we),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .byte_ready (byte_ready)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader. Expected writes are computed from the
// byte stream and queued when stimulus is issued. A negedge monitor pops and
// compares them whenever mem_we is seen.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [6:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim_q[$];

  int cyc = 0;
  int tb_checks = 0, tb_errors = 0;
  int mon_checks = 0, mon_errors = 0;
  int done_cnt = 0, done_cyc = 0, hold_cnt = 0, we_cnt = 0;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected writes on every strobe and tracks done/hold activity.
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt     <= we_cnt + 1;
      mon_checks <= mon_checks + 1;
      if (exp_q.size() == 0) begin
        mon_errors <= mon_errors + 1;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", mem_waddr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_waddr !== e.addr || mem_wdata !== e.data) begin
          mon_errors <= mon_errors + 1;
          $display("FAIL write_check: got addr %0d data %h, required addr %0d data %h",
                   mem_waddr, mem_wdata, e.addr, e.data);
        end
      end
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (cpu_hold) hold_cnt <= hold_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tb_checks++;
    if (act !== exp) begin
      tb_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Offer one byte; optionally pulse an illegal load_start in RECV or WRITE.
  task automatic send_byte(input logic [7:0] b, input bit ign_recv, input bit ign_write);
    int g;
    byte_valid = 1'b1;
    byte_data  = b;
    if (ign_recv) begin
      load_start = 1'b1;
      load_len   = 7'd0;
    end
    g = 0;
    while (!byte_ready && g < 20) begin
      if (ign_write) begin
        load_start = 1'b1;
        load_len   = 7'd0;
      end
      @(posedge clk); #1;
      load_start = 1'b0;
      g++;
    end
    chk("byte_ready_seen", 32'(byte_ready), 32'd1);
    @(posedge clk); #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = 6'(i);
      w.data = {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]};
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start(input logic [6:0] len);
    @(posedge clk); #1;
    load_start = 1'b1;
    load_len   = len;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Full session over stim_q with a given number of in-word stall cycles.
  task automatic run_load(input int len, input int stall_total, input bit ign);
    int d0, h0, w0, start_cyc, stall_left, used, s, g;
    push_words(len);
    d0 = done_cnt; h0 = hold_cnt; w0 = we_cnt;
    pulse_start(7'(len));
    start_cyc = cyc;
    chk("err_cleared_on_start", 32'(err), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("ready_after_start", 32'(byte_ready), 32'd1);
    stall_left = stall_total;
    used = 0;
    for (int k = 0; k < 4*len; k++) begin
      if (k % 4 != 0) begin
        s = (k == 4*len-1) ? stall_left : int'($urandom_range(0, stall_left));
        stall_left -= s;
        used += s;
        repeat (s) begin
          byte_valid = 1'b0;
          byte_data  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      send_byte(stim_q[k], ign && k == 1, ign && k == 4);
    end
    g = 0;
    while (done_cnt == d0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("done_latency", 32'(done_cyc - start_cyc), 32'(5*len + used));
    chk("hold_cycles", 32'(hold_cnt - h0), 32'(5*len + 1 + used));
    chk("write_count", 32'(we_cnt - w0), 32'(len));
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    chk("hold_released", 32'(cpu_hold), 32'd0);
    chk("busy_released", 32'(busy), 32'd0);
    chk("err_after_session", 32'(err), 32'd0);
  endtask

  task automatic bad_start(input logic [6:0] len);
    int w0;
    w0 = we_cnt;
    pulse_start(len);
    chk("err_set", 32'(err), 32'd1);
    chk("busy_idle_on_err", 32'(busy), 32'd0);
    chk("ready_idle_on_err", 32'(byte_ready), 32'd0);
    chk("hold_idle_on_err", 32'(cpu_hold), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_write_on_err", 32'(we_cnt - w0), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b0; load_start = 1'b0; load_len = 7'd0;
    byte_valid = 1'b0; byte_data = 8'd0;
    #2 rst = 1'b1;
    #3;
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_addr_data", {26'd0, mem_waddr} | mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic two-word load.
    stim_q = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h83, 8'h20, 8'h00, 8'h00};
    run_load(2, 0, 1'b0);

    // Same stream with three stall cycles.
    run_load(2, 3, 1'b0);

    // Length errors, then a valid single-word load clears err.
    bad_start(7'd0);
    bad_start(7'd65);
    bad_start(7'd127);
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, 0, 1'b0);

    // Illegal starts during RECV and WRITE are ignored.
    stim_q.delete();
    for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
    run_load(3, 0, 1'b1);

    // Reset after two bytes of word 1.
    stim_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55, 8'h66};
    push_words(1);
    w0 = we_cnt;
    pulse_start(7'd2);
    for (int k = 0; k < 6; k++) send_byte(stim_q[k], 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(byte_ready), 32'd0);
    chk("midrst_hold", 32'(cpu_hold), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_we_done_err", {29'd0, mem_we, done, err}, 32'd0);
    chk("midrst_addr_data", {26'd0, mem_waddr} | mem_wdata, 32'd0);
    chk("midrst_one_write", 32'(we_cnt - w0), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load(1, 0, 1'b0);

    // Full memory, byte value equals word index.
    stim_q.delete();
    for (int i = 0; i < 64; i++) repeat (4) stim_q.push_back(8'(i));
    run_load(64, 0, 1'b0);

    // Randomized sessions with random stalls and occasional bad starts.
    for (int r = 0; r < 5; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      stim_q.delete();
      for (int i = 0; i < 4*n; i++) stim_q.push_back(8'($urandom));
      if (r % 2 == 1) bad_start(7'($urandom_range(65, 127)));
      run_load(n, int'($urandom_range(0, 6)), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             tb_checks + mon_checks, tb_errors + mon_errors);
    $finish;
  end

endmodule
